iir_fold3_sched: RTL

- Controller and folded datapath for the 3-folded second-order IIR section: y[n] = b0·x[n] + a1·y[n-1] + a2·y[n-2].
- One multiplier, one 20-bit adder and one accumulator are reused over three fold phases per sample.
- Input and output are valid/ready handshakes; coefficients are loaded through a small register-write port.
- The block sits between the sample source and the downstream stage and owns all fold sequencing.

---
 rtl/iir_fold3_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/iir_fold3_sched.sv
// iir_fold3_sched: controller and folded datapath for a second-order IIR section,
//   y[n] = b0*x[n] + a1*y[n-1] + a2*y[n-2]
// One multiplier and one adder are shared across three fold phases per sample.
// Define IIR_FOLD3_SAT_EN to make the product and the sum saturate instead of wrap.
module iir_fold3_sched #(
    parameter int W    = 20,
    parameter int FRAC = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    input  logic         cfg_we,
    input  logic [1:0]   cfg_addr,
    input  logic [W-1:0] cfg_data,
    input  logic         hist_clr,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, P0, P1, P2, HOLD} state_t;

    state_t state, state_next;

    logic signed [W-1:0]   b0, a1, a2;
    logic signed [W-1:0]   x_reg, y1, y2, acc;
    logic signed [W-1:0]   mul_c, mul_v, add_a;
    logic signed [2*W-1:0] prod_full, prod_sh;
    logic signed [W-1:0]   prod_w, add_res;

`ifdef IIR_FOLD3_SAT_EN
    localparam logic signed [2*W-1:0] PMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] PMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]   SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   SMIN = {1'b1, {(W-1){1'b0}}};
    logic signed [W:0] sum_full;
`endif

    // Status outputs are pure decodes of the state register.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);

    // Operand selection for the shared multiplier and adder per fold phase.
    always_comb begin
        mul_c = '0;
        mul_v = '0;
        add_a = '0;
        case (state)
            P0: begin mul_c = b0; mul_v = x_reg; end
            P1: begin mul_c = a1; mul_v = y1; add_a = acc; end
            P2: begin mul_c = a2; mul_v = y2; add_a = acc; end
            default: ;
        endcase
    end

    // Shared multiplier: full-width product, floor shift, then wrap or saturate.
    always_comb begin
        prod_full = $signed({{W{mul_c[W-1]}}, mul_c}) * $signed({{W{mul_v[W-1]}}, mul_v});
        prod_sh   = prod_full >>> FRAC;
`ifdef IIR_FOLD3_SAT_EN
        if (prod_sh > PMAX)
            prod_w = SMAX;
        else if (prod_sh < PMIN)
            prod_w = SMIN;
        else
            prod_w = W'(prod_sh);
`else
        prod_w = W'(prod_sh);
`endif
    end

    // Shared adder: W-bit sum, wrap or saturate.
    always_comb begin
`ifdef IIR_FOLD3_SAT_EN
        sum_full = {add_a[W-1], add_a} + {prod_w[W-1], prod_w};
        if (sum_full[W] != sum_full[W-1])
            add_res = sum_full[W] ? SMIN : SMAX;
        else
            add_res = sum_full[W-1:0];
`else
        add_res = add_a + prod_w;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Fold sequencing: three compute phases, then hold until the output is taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = P0;
            P0:      state_next = P1;
            P1:      state_next = P2;
            P2:      state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers; config and history clear are only honoured in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0       <= '0;
            a1       <= '0;
            a2       <= '0;
            x_reg    <= '0;
            y1       <= '0;
            y2       <= '0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        case (cfg_addr)
                            2'd0:    b0 <= cfg_data;
                            2'd1:    a1 <= cfg_data;
                            2'd2:    a2 <= cfg_data;
                            default: ;
                        endcase
                    end
                    // History is read only from P1 on, so a clear on the accept edge is seen by that sample.
                    if (hist_clr) begin
                        y1 <= '0;
                        y2 <= '0;
                    end
                    if (in_valid)
                        x_reg <= in_data;
                end
                P0, P1: acc <= add_res;
                P2: begin
                    out_data <= add_res;
                    y2       <= y1;
                    y1       <= add_res;
                end
                default: ;
            endcase
        end
    end

endmodule
